seg7_signed_display: RTL
========================

# seg7_signed_display

Parametrised, sequential signed-binary to seven-segment display driver. It replaces the combinational divide/modulo digit extractor with an iterative double-dabble converter. It also adds a load/busy/valid handshake, a double-buffered display, and overflow indication. It sits between a result source (e.g. the CORDIC `cos_z0` output) and the board HEX displays, all on `clk_50`.

## Interface
- `WIDTH`, 17: width of the signed two's-complement input; ≥ 2.
- `DIGITS`, 5: number of decimal digits driven; ≥ 1.
- `clk_50`  in  1  system clock, all logic on its rising edge.
- `Reset`  in  1  synchronous, active-low reset; clock `clk_50`.
- `load`  in  1  request; samples `data_in` when idle.
- `data_in`  in  `WIDTH`  signed value to display.
- `busy`  out  1  high while a conversion is in progress.
- `valid`  out  1  one-cycle pulse when the display registers update.
- `seg_out`  out  `7*DIGITS`  active-low segments, digit k at bits [7k+6:7k], order {g,f,e,d,c,b,a}; digit 0 is the units digit.
- `Sig`  out  1  1 = positive or zero, 0 = negative.
- `overflow`  out  1  1 = magnitude ≥ 10^`DIGITS`.

## Operation
- FSM states: IDLE, CONV, UPDATE.
- **IDLE:**
  - If `load`=1, capture sign = `data_in[WIDTH-1]`.
  - Capture magnitude = |`data_in`| as a `WIDTH`-bit unsigned value. The most negative input maps to 2^(`WIDTH`-1) with no saturation.
  - Clear the BCD register (4·`DIGITS` bits) and the sticky overflow flag.
  - Clear the bit counter, then go to CONV.
- **CONV:**
  - One double-dabble step per cycle: every BCD nibble ≥ 5 gets +3, then shift {BCD, magnitude} left by 1.
  - Any 1 shifted out of the top nibble sets sticky overflow.
  - After exactly `WIDTH` steps, go to UPDATE.
- **UPDATE:**
  - Load the `seg_out`, `Sig` and `overflow` registers from the working registers.
  - Assert `valid` for this cycle only, then go to IDLE.
- **Decode:**
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10.
  - Invalid nibble → 7'h7F (blank).
- **Overflow:** every digit shows dash 7'h3F; `Sig` still reflects the sign.
- **Display buffering:** display registers hold the previous result throughout CONV; there is no intermediate flicker.
- **`load` while `busy`:** ignored, not queued.
- **Reset (`Reset`=0 at an edge):** FSM → IDLE from any state, including mid-CONV; the conversion in progress is abandoned.
- **Reset values:** `seg_out` all 7'h7F, `Sig`=1, `overflow`=0, `valid`=0, `busy`=0.
- **Simultaneous `Reset`=0 and `load`=1:** reset wins.

## Timing
- Edge E0: `load` sampled in IDLE.
- Edges E1..E`WIDTH`: conversion steps.
- Edge E`WIDTH`+1: display registers update.
- `busy` is registered: 1 from after E0 until E`WIDTH`+1, i.e. `WIDTH`+1 cycles.
- `valid` is high in the cycle following E`WIDTH`+1.
- Latency from `load` to new display is `WIDTH`+1 cycles (18 at defaults).
- The next `load` is accepted in the first cycle with `busy`=0; `load` may be held high, giving back-to-back conversions every `WIDTH`+2 cycles.
- All outputs are registered; no combinational path from the inputs.

## Configuration
- `SEG7_LZB_EN` defined:
  - Leading-zero blanking: digits above the most significant nonzero digit output 7'h7F.
  - Digit 0 is never blanked.
  - Not applied on overflow (all dashes).
- `SEG7_LZB_EN` undefined: all `DIGITS` digits shown, leading zeros as 7'h40.

## Test plan
- **Negative value:** defaults, `load` with `data_in`=-1234 → after 18 cycles `valid` pulses, `Sig`=0, `overflow`=0. Digits 4..0 are 7'h40,7'h79,7'h24,7'h30,7'h19; digit 4 is 7'h7F with `SEG7_LZB_EN`.
- **Most negative input:** `data_in`=-65536 → `Sig`=0, digits 6,5,5,3,6 (7'h02,7'h12,7'h12,7'h30,7'h02), `overflow`=0.
- **Zero:** `data_in`=0 → `Sig`=1, digit 0 = 7'h40; other digits are 7'h7F with `SEG7_LZB_EN`, else 7'h40.
- **Overflow:** `DIGITS`=4, `data_in`=12345 → `overflow`=1, all four digits 7'h3F, `Sig`=1.
- **`load` while busy:** convert 42, pulse `load` with 999 at cycle 5 → display shows 42, exactly one `valid` pulse. A subsequent `load` of 999 after `busy` falls → 999.
- **Reset mid-conversion:** `Reset`=0 at cycle 8 of a conversion → next cycle `busy`=0, `seg_out` all 7'h7F, `Sig`=1, no `valid`. A new `load` after reset converts normally.

Source files
------------

// File: rtl/seg7_signed_display_if.sv
// Handshake and display bundle for seg7_signed_display.
// The source (master) drives load/data_in; the display driver (slave) drives the rest.
interface seg7_signed_display_if #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned DIGITS = 5
) ();
  logic                  load;
  logic [WIDTH-1:0]      data_in;
  logic                  busy;
  logic                  valid;
  logic [7*DIGITS-1:0]   seg_out;
  logic                  Sig;
  logic                  overflow;

  modport master (
    output load, data_in,
    input  busy, valid, seg_out, Sig, overflow
  );

  modport slave (
    input  load, data_in,
    output busy, valid, seg_out, Sig, overflow
  );
endinterface

// File: rtl/seg7_signed_display.sv
// Signed binary to active-low seven-segment driver using a sequential double-dabble converter.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_signed_display #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned DIGITS = 5
) (
  input logic                  clk_50,
  input logic                  Reset,
  seg7_signed_display_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7*DIGITS-1:0]   seg_q, seg_d;
  logic                  sig_q, sig_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic [BcdW-1:0]       adj;
  logic [7*DIGITS-1:0]   disp;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h7F;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
`ifdef SEG7_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    disp = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
`ifdef SEG7_LZB_EN
      // Blank zeros above the most significant nonzero digit; units always shown.
      if (lead && (bcd_q[4*k +: 4] == 4'd0) && (k != 0)) begin
        disp[7*k +: 7] = 7'h7F;
      end else begin
        lead = 1'b0;
        disp[7*k +: 7] = dec7(bcd_q[4*k +: 4]);
      end
`else
      disp[7*k +: 7] = dec7(bcd_q[4*k +: 4]);
`endif
      if (ovf_q) disp[7*k +: 7] = 7'h3F;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    seg_d      = seg_q;
    sig_d      = sig_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      StIdle: begin
        if (bus.load) begin
          sign_d  = bus.data_in[WIDTH-1];
          // Most negative input wraps to 2^(WIDTH-1), which fits as unsigned.
          mag_d   = bus.data_in[WIDTH-1] ? (~bus.data_in + 1'b1) : bus.data_in;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        {bcd_d, mag_d} = {adj, mag_q} << 1;
        ovf_d          = ovf_q | adj[BcdW-1];
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StUpdate;
      end
      StUpdate: begin
        seg_d      = disp;
        sig_d      = ~sign_q;
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!Reset) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      seg_q      <= {DIGITS{7'h7F}};
      sig_q      <= 1'b1;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_d;
      sig_q      <= sig_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.seg_out  = seg_q;
  assign bus.Sig      = sig_q;
  assign bus.overflow = overflow_q;

endmodule
